// File: rtl/flash_seq_pkg.sv
// Shared definitions for the SPI-flash command sequencer.
// Contents: sequencer state encoding, common flash opcodes, byte width.
package flash_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    TX,
    WAIT_RX
  } state_t;

  localparam logic [BYTE_W-1:0] OP_RDID = 8'h9F;
  localparam logic [BYTE_W-1:0] OP_READ = 8'h03;
  localparam logic [BYTE_W-1:0] OP_WREN = 8'h06;
  localparam logic [BYTE_W-1:0] OP_PP   = 8'h02;
  localparam logic [BYTE_W-1:0] OP_SE   = 8'hD8;
  localparam logic [BYTE_W-1:0] OP_RDSR = 8'h05;

endpackage

// File: rtl/flash_seq_sdpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Ports:
//   axi_aclk        clock
//   we/waddr/wdata  write port
//   raddr/rdata     read port, rdata valid one cycle after raddr
// A read and a write to the same entry in one cycle returns the old data.
module flash_seq_sdpram #(
  parameter  int DEPTH = 256,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             axi_aclk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset so it maps onto block RAM; contents survive reset.
  always_ff @(posedge axi_aclk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/flash_cmd_seq.sv
// SPI-flash command sequencer for the flash AXI-Stream path of the QSPI core.
// Software loads cmd_* and the write buffer, then pulses cmd_start. The block
// sends opcode, address (MSB first), dummy 0x00, write bytes and read-filler
// 0x00 on m_axis, and stores the read-phase bytes returned on s_axis in rbuf.
// Ports:
//   axi_aclk, axi_aresetn      clock, synchronous active-low reset
//   cmd_*                      command fields, latched on an accepted cmd_start
//   busy, done, err            status; done/err sticky until next accepted start
//   wbuf_we/addr/data          write-buffer load port
//   rbuf_addr, rbuf_data       read-buffer read port (1-cycle latency)
//   m_axis_*                   bytes to the QSPI core
//   s_axis_*                   bytes from the QSPI core
// Optional build macro FLASH_SEQ_TIMEOUT_EN: aborts a sequence that has been
// busy for TIMEOUT cycles, raising err and done.
module flash_cmd_seq
  import flash_seq_pkg::*;
#(
  parameter  int ADDR_BYTES = 3,
  parameter  int BUF_DEPTH  = 256,
  parameter  int TIMEOUT    = 2**20,
  localparam int AW         = $clog2(BUF_DEPTH)
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic              cmd_start,
  input  logic [BYTE_W-1:0] cmd_opcode,
  input  logic [31:0]       cmd_addr,
  input  logic              cmd_addr_en,
  input  logic [3:0]        cmd_dummy,
  input  logic [8:0]        cmd_wr_len,
  input  logic [8:0]        cmd_rd_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              wbuf_we,
  input  logic [AW-1:0]     wbuf_addr,
  input  logic [BYTE_W-1:0] wbuf_data,
  input  logic [AW-1:0]     rbuf_addr,
  output logic [BYTE_W-1:0] rbuf_data,
  output logic [BYTE_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  input  logic [BYTE_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready
);

  // Wide enough for the longest sequence: 1 + 4 + 15 + 2*BUF_DEPTH bytes.
  localparam int CNT_W = $clog2(2 * BUF_DEPTH + 21);

  state_t state_q, state_d;

  logic [BYTE_W-1:0] op_q;
  logic [31:0]       addr_q;
  logic              addr_en_q;
  logic [3:0]        dummy_q;
  logic [8:0]        wr_len_q, rd_len_q;
  logic [CNT_W-1:0]  tx_idx_q, rx_idx_q;
  logic              rx_all_q, done_q, err_q, rx_rdy_q;

  // Phase boundaries: first index after opcode+address, after dummy, after write.
  logic [CNT_W-1:0] addr_end, dummy_end, wr_end, n_last, tx_nxt;
  logic [BYTE_W-1:0] tx_byte, wbuf_rdata;
  logic tx_fire, rx_fire, rx_last, len_bad, accept, seq_end, tmo_hit;

  assign addr_end  = CNT_W'(1) + (addr_en_q ? CNT_W'(ADDR_BYTES) : '0);
  assign dummy_end = addr_end + CNT_W'(dummy_q);
  assign wr_end    = dummy_end + CNT_W'(wr_len_q);
  assign n_last    = wr_end + CNT_W'(rd_len_q) - CNT_W'(1);

  assign len_bad = (int'(cmd_wr_len) > BUF_DEPTH) || (int'(cmd_rd_len) > BUF_DEPTH);
  assign accept  = (state_q == IDLE) && cmd_start;

  assign m_axis_tvalid = (state_q == TX);
  assign m_axis_tdata  = m_axis_tvalid ? tx_byte : '0;
  assign m_axis_tlast  = m_axis_tvalid && (tx_idx_q == n_last);
  assign tx_fire       = m_axis_tvalid && m_axis_tready;

  assign s_axis_tready = rx_rdy_q;
  assign rx_fire = (state_q != IDLE) && s_axis_tvalid && s_axis_tready && !rx_all_q;
  assign rx_last = rx_fire && (rx_idx_q == n_last);

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign err  = err_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    tx_byte = '0;
    if (tx_idx_q == '0) begin
      tx_byte = op_q;
    end else if (tx_idx_q < addr_end) begin
      // Index i carries address byte ADDR_BYTES-i, so the MSB goes first.
      for (int b = 0; b < 4; b++) begin
        if (b < ADDR_BYTES && tx_idx_q == CNT_W'(ADDR_BYTES - b)) tx_byte = addr_q[8*b +: 8];
      end
    end else if (tx_idx_q >= dummy_end && tx_idx_q < wr_end) begin
      tx_byte = wbuf_rdata;
    end
  end

  // The write buffer is addressed with the index of the byte presented next
  // cycle, so its registered output is ready in time and TX never bubbles.
  assign tx_nxt = (state_q == IDLE) ? '0 : tx_idx_q + CNT_W'(tx_fire);

  flash_seq_sdpram #(.DEPTH(BUF_DEPTH), .WIDTH(BYTE_W)) u_wbuf (
    .axi_aclk (axi_aclk),
    .we       (wbuf_we),
    .waddr    (wbuf_addr),
    .wdata    (wbuf_data),
    .raddr    (AW'(tx_nxt - dummy_end)),
    .rdata    (wbuf_rdata)
  );

  flash_seq_sdpram #(.DEPTH(BUF_DEPTH), .WIDTH(BYTE_W)) u_rbuf (
    .axi_aclk (axi_aclk),
    .we       (rx_fire && (rx_idx_q >= wr_end)),
    .waddr    (AW'(rx_idx_q - wr_end)),
    .wdata    (s_axis_tdata),
    .raddr    (rbuf_addr),
    .rdata    (rbuf_data)
  );

`ifdef FLASH_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;

  assign tmo_hit = busy && (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn || accept) tmo_q <= '0;
    else if (busy)              tmo_q <= tmo_q + TW'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_start && !len_bad) state_d = TX;
      // rx normally trails tx; if it has already finished, skip WAIT_RX.
      TX:      if (tx_fire && tx_idx_q == n_last) state_d = (rx_all_q || rx_last) ? IDLE : WAIT_RX;
      WAIT_RX: if (rx_all_q || rx_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tmo_hit) state_d = IDLE;
  end

  assign seq_end = (state_q != IDLE) && (state_d == IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process order.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      op_q      <= '0;
      addr_q    <= '0;
      addr_en_q <= 1'b0;
      dummy_q   <= '0;
      wr_len_q  <= '0;
      rd_len_q  <= '0;
      tx_idx_q  <= '0;
      rx_idx_q  <= '0;
      rx_all_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rx_rdy_q  <= 1'b0;
    end else begin
      rx_rdy_q <= 1'b1;
      if (accept) begin
        // A length error completes at once, flagged, without any transfer.
        done_q <= len_bad;
        err_q  <= len_bad;
        if (!len_bad) begin
          op_q      <= cmd_opcode;
          addr_q    <= cmd_addr;
          addr_en_q <= cmd_addr_en;
          dummy_q   <= cmd_dummy;
          wr_len_q  <= cmd_wr_len;
          rd_len_q  <= cmd_rd_len;
          tx_idx_q  <= '0;
          rx_idx_q  <= '0;
          rx_all_q  <= 1'b0;
        end
      end else begin
        if (tx_fire) tx_idx_q <= tx_idx_q + CNT_W'(1);
        if (rx_fire) begin
          rx_idx_q <= rx_idx_q + CNT_W'(1);
          // tlast must mark exactly the final rx byte; anything else is framing.
          if (s_axis_tlast != (rx_idx_q == n_last)) err_q <= 1'b1;
          if (rx_last) rx_all_q <= 1'b1;
        end
        if (tmo_hit) err_q  <= 1'b1;
        if (seq_end) done_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flash_cmd_seq.sv
// Self-checking bench for flash_cmd_seq. A loopback model returns ~tx on s_axis
// with tlast echoed; expected tx bytes go into a scoreboard queue that a
// monitor drains on every m_axis handshake.
module tb_flash_cmd_seq;
  import flash_seq_pkg::*;

  logic       axi_aclk = 1'b0;
  logic       axi_aresetn;
  logic       cmd_start;
  logic [7:0] cmd_opcode;
  logic [31:0] cmd_addr;
  logic       cmd_addr_en;
  logic [3:0] cmd_dummy;
  logic [8:0] cmd_wr_len, cmd_rd_len;
  logic       busy, done, err;
  logic       wbuf_we;
  logic [7:0] wbuf_addr, wbuf_data, rbuf_addr, rbuf_data;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid, s_axis_tlast, s_axis_tready;

  always #5 axi_aclk = ~axi_aclk;

  flash_cmd_seq #(.ADDR_BYTES(3), .BUF_DEPTH(256), .TIMEOUT(64)) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .cmd_start(cmd_start), .cmd_opcode(cmd_opcode), .cmd_addr(cmd_addr),
    .cmd_addr_en(cmd_addr_en), .cmd_dummy(cmd_dummy),
    .cmd_wr_len(cmd_wr_len), .cmd_rd_len(cmd_rd_len),
    .busy(busy), .done(done), .err(err),
    .wbuf_we(wbuf_we), .wbuf_addr(wbuf_addr), .wbuf_data(wbuf_data),
    .rbuf_addr(rbuf_addr), .rbuf_data(rbuf_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int tx_seen = 0;
  logic [8:0] exp_q[$];   // {tlast, data} expected on m_axis
  logic [8:0] loop_q[$];  // {tlast, ~data} to return on s_axis
  logic [7:0] wb[256];
  bit tx_hs, rx_hs;
  bit rx_stall = 0, rx_mix = 0, tready_tgl = 0;
  int inj_idx = -1;
  int rx_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor + loopback model. Samples on negedge, drives #1 after posedge.
  initial begin
    logic [8:0] e, r;
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    forever begin
      @(negedge axi_aclk);
      tx_hs = m_axis_tvalid && m_axis_tready;
      rx_hs = s_axis_tvalid && s_axis_tready;
      if (tx_hs) begin
        tx_seen++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL tx_unexpected: got 0x%0h, expected no byte", {m_axis_tlast, m_axis_tdata});
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", {m_axis_tlast, m_axis_tdata}, e);
        end
        loop_q.push_back({m_axis_tlast, ~m_axis_tdata});
      end
      @(posedge axi_aclk); #1;
      if (!axi_aresetn) begin
        loop_q.delete();
        s_axis_tvalid = 1'b0;
        rx_cnt = 0;
      end else begin
        if (rx_hs) s_axis_tvalid = 1'b0;
        if (!s_axis_tvalid && !rx_stall && loop_q.size() != 0) begin
          r = loop_q.pop_front();
          s_axis_tvalid = 1'b1;
          s_axis_tdata  = r[7:0] ^ (rx_mix ? 8'(rx_cnt) : 8'h00);
          s_axis_tlast  = r[8] || (rx_cnt == inj_idx);
          rx_cnt = r[8] ? 0 : rx_cnt + 1;
        end
      end
      m_axis_tready = tready_tgl ? !m_axis_tready : 1'b1;
    end
  end

  task automatic tick();
    @(posedge axi_aclk); #1;
  endtask

  task automatic wbuf_write(input int a, input logic [7:0] d);
    wb[a] = d;
    wbuf_we = 1'b1; wbuf_addr = 8'(a); wbuf_data = d;
    tick();
    wbuf_we = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] op, input logic [31:0] addr, input bit aen,
                          input int dummy, input int wl, input int rl);
    logic [7:0] b[$];
    b.push_back(op);
    if (aen) begin
      b.push_back(addr[23:16]); b.push_back(addr[15:8]); b.push_back(addr[7:0]);
    end
    for (int i = 0; i < dummy; i++) b.push_back(8'h00);
    for (int i = 0; i < wl; i++)    b.push_back(wb[i]);
    for (int i = 0; i < rl; i++)    b.push_back(8'h00);
    foreach (b[i]) exp_q.push_back({(i == b.size() - 1), b[i]});
  endtask

  task automatic start_cmd(input logic [7:0] op, input logic [31:0] addr, input bit aen,
                           input int dummy, input int wl, input int rl);
    cmd_opcode = op; cmd_addr = addr; cmd_addr_en = aen;
    cmd_dummy = 4'(dummy); cmd_wr_len = 9'(wl); cmd_rd_len = 9'(rl);
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit ok = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge axi_aclk);
      if (done) begin ok = 1; break; end
    end
    check({nm, "_done"}, ok, 1);
    tick();
  endtask

  task automatic run_cmd(input string nm, input logic [7:0] op, input logic [31:0] addr,
                         input bit aen, input int dummy, input int wl, input int rl,
                         input bit exp_err);
    push_exp(op, addr, aen, dummy, wl, rl);
    start_cmd(op, addr, aen, dummy, wl, rl);
    wait_done(nm);
    check({nm, "_err"}, err, exp_err);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_txq_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_rbuf(input int a, input logic [7:0] e);
    rbuf_addr = 8'(a);
    tick();
    check($sformatf("rbuf[%0d]", a), rbuf_data, e);
  endtask

  initial begin
    int seen0;
    axi_aresetn = 1'b0; cmd_start = 1'b0; cmd_opcode = '0; cmd_addr = '0;
    cmd_addr_en = 1'b0; cmd_dummy = '0; cmd_wr_len = '0; cmd_rd_len = '0;
    wbuf_we = 1'b0; wbuf_addr = '0; wbuf_data = '0; rbuf_addr = '0;
    foreach (wb[i]) wb[i] = 8'h00;
    repeat (3) tick();

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_s_tready", s_axis_tready, 0);
    axi_aresetn = 1'b1;
    tick();
    check("idle_s_tready", s_axis_tready, 1);

    // RDID: 9F,00,00,00; rbuf 0..2 = FF
    run_cmd("rdid", OP_RDID, 32'h0, 0, 0, 0, 3, 0);
    check("rdid_done", done, 1);
    for (int i = 0; i < 3; i++) check_rbuf(i, 8'hFF);

    // READ with toggling tready: 03,12,34,56,00x4
    tready_tgl = 1;
    run_cmd("read", OP_READ, 32'h00123456, 1, 0, 0, 4, 0);
    tready_tgl = 0;
    for (int i = 0; i < 4; i++) check_rbuf(i, 8'hFF);

    // Fast read with one dummy; rx = ~tx ^ frame index, so the read phase
    // (indices 5..7 of 8) lands as FA, F9, F8.
    rx_mix = 1;
    run_cmd("fread", 8'h0B, 32'h00ABCDEF, 1, 1, 0, 3, 0);
    rx_mix = 0;
    check_rbuf(0, 8'hFA);
    check_rbuf(1, 8'hF9);
    check_rbuf(2, 8'hF8);
    check_rbuf(3, 8'hFF);

    // WREN then PP 02,00,01,00,A5,5A; rbuf left untouched
    wbuf_write(0, 8'hA5);
    wbuf_write(1, 8'h5A);
    run_cmd("wren", OP_WREN, 32'h0, 0, 0, 0, 0, 0);
    run_cmd("pp", OP_PP, 32'h00000100, 1, 0, 2, 0, 0);
    check_rbuf(0, 8'hFA);
    check_rbuf(1, 8'hF9);

    // Length error: immediate err/done, no m_axis activity
    seen0 = tx_seen;
    start_cmd(OP_READ, 32'h0, 1, 0, 0, 300);
    check("len_err", err, 1);
    check("len_done", done, 1);
    check("len_busy", busy, 0);
    repeat (5) tick();
    check("len_no_tx", tx_seen, seen0);

    // Early rx tlast on byte 2 of 4: sequence completes, err flagged
    inj_idx = 1;
    run_cmd("early_tlast", OP_RDSR, 32'h0, 0, 0, 0, 3, 1);
    inj_idx = -1;

    // cmd_start while busy is ignored
    tready_tgl = 1;
    push_exp(OP_READ, 32'h00000040, 1, 0, 0, 8);
    start_cmd(OP_READ, 32'h00000040, 1, 0, 0, 8);
    repeat (2) tick();
    start_cmd(OP_RDID, 32'h0, 0, 0, 0, 1);
    wait_done("busy_start");
    tready_tgl = 0;
    check("busy_start_err", err, 0);
    check("busy_start_txq", exp_q.size(), 0);
    check_rbuf(0, 8'hFF);

    // Reset mid-TX: tvalid drops on the next cycle
    push_exp(OP_READ, 32'h0, 1, 0, 0, 20);
    start_cmd(OP_READ, 32'h0, 1, 0, 0, 20);
    repeat (3) tick();
    axi_aresetn = 1'b0;
    tick();
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_busy", busy, 0);
    exp_q.delete();
    tick();
    check("midrst_s_tready", s_axis_tready, 0);
    axi_aresetn = 1'b1;
    repeat (2) tick();
    run_cmd("post_rst_rdid", OP_RDID, 32'h0, 0, 0, 0, 3, 0);
    for (int i = 0; i < 3; i++) check_rbuf(i, 8'hFF);

    // Stalled rx model
    rx_stall = 1;
    push_exp(OP_RDSR, 32'h0, 0, 0, 0, 3);
    start_cmd(OP_RDSR, 32'h0, 0, 0, 0, 3);
`ifdef FLASH_SEQ_TIMEOUT_EN
    repeat (63) tick();
    check("tmo_busy_before", busy, 1);
    tick();
    check("tmo_busy", busy, 0);
    check("tmo_err", err, 1);
    check("tmo_done", done, 1);
`else
    repeat (100) tick();
    check("stall_busy", busy, 1);
    check("stall_done", done, 0);
`endif
    check("stall_txq", exp_q.size(), 0);
    axi_aresetn = 1'b0;
    repeat (2) tick();
    rx_stall = 0;
    axi_aresetn = 1'b1;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
